// File: rtl/elevator_car_controller.sv
// elevator_car_controller
// Car-motion stage that sits downstream of the direction calculator. It moves
// the car one floor at a time under a travel timer and opens the door for
// calls at the current floor. It pulses a one-hot clear back to the call
// register. currentFloor is owned here and feeds back to the direction
// calculator.
module elevator_car_controller #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       direction,
    input  logic       shouldMove,
    input  logic [7:0] floorsCalled,
    output logic [2:0] currentFloor,
    output logic       moving,
    output logic       doorOpen,
    output logic       arrived,
    output logic [7:0] clearFloor
);

    // Zero-length timers behave as one cycle; the counter is 8 bits wide.
    localparam int TRAVEL_EFF = (TRAVEL_CYCLES < 1) ? 1 :
                                (TRAVEL_CYCLES > 255) ? 255 : TRAVEL_CYCLES;
    localparam int DOOR_EFF   = (DOOR_CYCLES < 1) ? 1 :
                                (DOOR_CYCLES > 255) ? 255 : DOOR_CYCLES;
    localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_EFF - 1);
    localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_EFF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    state_t     state;
    logic       dir_reg;
    logic [7:0] counter;

    logic call_here;
    logic at_boundary;
    logic first_door_cycle;

    function automatic logic [7:0] one_hot(input logic [2:0] floor_idx);
        return 8'b0000_0001 << floor_idx;
    endfunction

    // Decode of the current-floor call and the top/bottom travel limits.
    // While clearFloor is pulsing the upstream register has not dropped the
    // bit yet, so that cycle must not count as a fresh re-call.
    always_comb begin
        call_here        = floorsCalled[currentFloor];
        at_boundary      = (direction  && (currentFloor == 3'd7)) ||
                           (!direction && (currentFloor == 3'd0));
        first_door_cycle = |clearFloor;
    end

    // Car FSM: state, timer, floor position and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            dir_reg      <= 1'b0;
            counter      <= 8'd0;
            currentFloor <= 3'd0;
            moving       <= 1'b0;
            doorOpen     <= 1'b0;
            arrived      <= 1'b0;
            clearFloor   <= 8'h00;
        end else begin
            arrived    <= 1'b0;
            clearFloor <= 8'h00;
            case (state)
                IDLE: begin
                    if (arrived) begin
                        // Arrival cycle: hold still so the direction
                        // calculator can see the new floor before we act.
                        state <= IDLE;
                    end else if (call_here) begin
                        state      <= DOOR;
                        counter    <= DOOR_LOAD;
                        doorOpen   <= 1'b1;
                        clearFloor <= one_hot(currentFloor);
                    end else if (shouldMove && !at_boundary) begin
                        state   <= MOVE;
                        dir_reg <= direction;
                        counter <= TRAVEL_LOAD;
                        moving  <= 1'b1;
                    end
                end
                MOVE: begin
                    if (counter == 8'd0) begin
                        currentFloor <= dir_reg ? currentFloor + 3'd1
                                                : currentFloor - 3'd1;
                        state        <= IDLE;
                        moving       <= 1'b0;
                        arrived      <= 1'b1;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                DOOR: begin
                    if (!first_door_cycle && call_here) begin
                        // Someone pressed the call again: hold the door open.
                        counter    <= DOOR_LOAD;
                        clearFloor <= one_hot(currentFloor);
                    end else if (counter == 8'd0) begin
                        state    <= IDLE;
                        doorOpen <= 1'b0;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    moving   <= 1'b0;
                    doorOpen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_car_controller.sv
// tb_elevator_car_controller
// Directed bench for elevator_car_controller with TRAVEL_CYCLES=4 and
// DOOR_CYCLES=3. It runs a vector table of per-cycle inputs and expected
// outputs, then hand-written sequences for door extension, the top/bottom
// limits and reset during travel.
module tb_elevator_car_controller;

    logic       clock;
    logic       reset;
    logic       direction;
    logic       shouldMove;
    logic [7:0] floorsCalled;
    logic [2:0] currentFloor;
    logic       moving;
    logic       doorOpen;
    logic       arrived;
    logic [7:0] clearFloor;

    int nchecks = 0;
    int nfail   = 0;

    typedef struct {
        logic       dir;
        logic       sm;
        logic [7:0] fc;
        logic [2:0] cf;
        logic       mv;
        logic       dr;
        logic       ar;
        logic [7:0] cl;
    } vec_t;

    vec_t tbl[$];

    elevator_car_controller #(
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .direction   (direction),
        .shouldMove  (shouldMove),
        .floorsCalled(floorsCalled),
        .currentFloor(currentFloor),
        .moving      (moving),
        .doorOpen    (doorOpen),
        .arrived     (arrived),
        .clearFloor  (clearFloor)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic dir, input logic sm, input logic [7:0] fc,
                                input logic [2:0] cf, input logic mv, input logic dr,
                                input logic ar, input logic [7:0] cl);
        vec_t v;
        v.dir = dir; v.sm = sm; v.fc = fc;
        v.cf = cf; v.mv = mv; v.dr = dr; v.ar = ar; v.cl = cl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [2:0] cf, input logic mv,
                           input logic dr, input logic ar, input logic [7:0] cl);
        nchecks++;
        if ({currentFloor, moving, doorOpen, arrived, clearFloor} !== {cf, mv, dr, ar, cl}) begin
            nfail++;
            $display("FAIL %s: got floor=%0d mv=%b door=%b arr=%b clr=%h, expected floor=%0d mv=%b door=%b arr=%b clr=%h",
                     name, currentFloor, moving, doorOpen, arrived, clearFloor, cf, mv, dr, ar, cl);
        end
    endtask

    task automatic drive(input logic dir, input logic sm, input logic [7:0] fc);
        @(negedge clock);
        direction    = dir;
        shouldMove   = sm;
        floorsCalled = fc;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_arrival(input logic [2:0] exp_floor);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (arrived) seen = 1'b1;
        end
        if (!seen) begin
            nchecks++;
            nfail++;
            $display("FAIL arrival_timeout: no arrived pulse in 20 cycles, required floor %0d", exp_floor);
        end else begin
            chk($sformatf("arrival_floor_%0d", exp_floor), 32'(currentFloor), 32'(exp_floor));
        end
    endtask

    initial begin
        direction    = 1'b0;
        shouldMove   = 1'b0;
        floorsCalled = 8'h00;
        reset        = 1'b0;

        // Floor 0 downward request is a boundary: ignored.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 8'h00));
        // Call at floor 0: door for 3 cycles, one clear pulse.
        tbl.push_back(mk(0, 0, 8'h01, 0, 0, 1, 0, 8'h01));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
        // Travel up two floors toward a call at floor 2.
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 8'h04, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 8'h04, 1, 0, 0, 1, 8'h00));
        tbl.push_back(mk(1, 1, 8'h04, 1, 0, 0, 0, 8'h00));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 8'h04, 1, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 8'h04, 2, 0, 0, 1, 8'h00));
        tbl.push_back(mk(0, 0, 8'h04, 2, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 8'h04, 2, 0, 1, 0, 8'h04));
        tbl.push_back(mk(0, 0, 8'h00, 2, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 2, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 2, 0, 0, 0, 8'h00));

        // Asynchronous reset asserted between edges.
        #2;
        reset = 1'b1;
        #1;
        chk_all("reset_async", 0, 0, 0, 0, 8'h00);
        tick();
        tick();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("reset_hold%0d", i), 0, 0, 0, 0, 8'h00);
        end

        // Vector table.
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].dir, tbl[k].sm, tbl[k].fc);
            tick();
            chk_all($sformatf("vec%0d", k), tbl[k].cf, tbl[k].mv, tbl[k].dr, tbl[k].ar, tbl[k].cl);
        end

        // Move to floor 3, then door extension by a re-call in the 2nd door cycle.
        drive(1, 1, 8'h00);
        wait_arrival(3);
        drive(0, 0, 8'h08);
        tick(); chk_all("ext_settle", 3, 0, 0, 0, 8'h00);
        drive(0, 0, 8'h08);
        tick(); chk_all("ext_door1", 3, 0, 1, 0, 8'h08);
        drive(0, 0, 8'h00);
        tick(); chk_all("ext_door2", 3, 0, 1, 0, 8'h00);
        drive(0, 0, 8'h08);
        tick(); chk_all("ext_reclear", 3, 0, 1, 0, 8'h08);
        drive(0, 0, 8'h00);
        tick(); chk_all("ext_hold1", 3, 0, 1, 0, 8'h00);
        tick(); chk_all("ext_hold2", 3, 0, 1, 0, 8'h00);
        tick(); chk_all("ext_close", 3, 0, 0, 0, 8'h00);

        // Climb to floor 7 and request further up: ignored.
        drive(1, 1, 8'h00);
        for (int f = 4; f <= 7; f++) wait_arrival(3'(f));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("top_stay%0d", i), {29'd0, currentFloor, moving}, {29'd0, 3'd7, 1'b0});
        end

        // Descend to floor 2, start one more move down, reset mid-travel.
        drive(0, 1, 8'h00);
        for (int f = 6; f >= 2; f--) wait_arrival(3'(f));
        tick(); chk_all("dn_settle", 2, 0, 0, 0, 8'h00);
        tick(); chk_all("dn_move1", 2, 1, 0, 0, 8'h00);
        tick(); chk_all("dn_move2", 2, 1, 0, 0, 8'h00);
        #3;
        reset = 1'b1;
        #1;
        chk_all("abort_reset", 0, 0, 0, 0, 8'h00);
        @(negedge clock);
        @(negedge clock);
        reset      = 1'b0;
        shouldMove = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all($sformatf("abort_after%0d", i), 0, 0, 0, 0, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchecks, nfail);
        $finish;
    end

endmodule
